// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: entry layout, the
// register-file forwarding code and the select-width helper.
package hazard_pkg;

   localparam int FWD_RF = 0;

   // Entries carry the widest register index supported; narrower indices are zero-extended.
   localparam int MAX_REG_ADDR_W = 8;

   typedef struct packed {
      logic                      v;
      logic [MAX_REG_ADDR_W-1:0] rd;
      logic                      ld;
   } sb_entry_t;

   function automatic int fwd_sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sb_src_match.sv
// Finds the youngest in-flight producer of one source operand; the WB stage is
// excluded because the write-first register file already returns its data.
module sb_src_match
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int SEL_W      = 2
) (
   input  sb_entry_t [NUM_STAGES-1:0]  entries,
   input  logic [MAX_REG_ADDR_W-1:0]   srcIdx,
   input  logic                        srcUsed,
   output logic                        hit,
   output logic [SEL_W-1:0]            stage,
   output logic                        isLoad
);

   // Scan oldest to youngest so the smallest matching stage index is the one that sticks.
   always_comb begin
      hit    = 1'b0;
      stage  = '0;
      isLoad = 1'b0;
      for (int j = NUM_STAGES - 2; j >= 0; j--) begin
         if (entries[j].v && srcUsed && (srcIdx != '0) && (entries[j].rd == srcIdx)) begin
            hit    = 1'b1;
            stage  = SEL_W'(j);
            isLoad = entries[j].ld;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding control for the in-order RV32 pipeline.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES       = 3,
   parameter int REG_ADDR_W       = 5,
   parameter int LOAD_READY_STAGE = 2,
   parameter int SEL_W            = fwd_sel_width(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  id_valid,
   input  logic                  flush_id,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_is_load,
   output logic                  stall_out,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  ex_bubble,
   output logic [SEL_W-1:0]      fwd_sel_rs1_ex,
   output logic [SEL_W-1:0]      fwd_sel_rs2_ex
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]           stat_stall_cycles,
   output logic [31:0]           stat_fwd_events
`endif
);

   sb_entry_t [NUM_STAGES-1:0] entries;
   sb_entry_t                  newEntry;

   logic             hitRs1, hitRs2;
   logic             ldRs1, ldRs2;
   logic [SEL_W-1:0] stageRs1, stageRs2;
   logic [SEL_W-1:0] selRs1, selRs2;
   logic             loadUseRs1, loadUseRs2;
   logic             issueValid;

   sb_src_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) matchRs1 (
      .entries (entries),
      .srcIdx  (MAX_REG_ADDR_W'(id_rs1)),
      .srcUsed (id_rs1_used),
      .hit     (hitRs1),
      .stage   (stageRs1),
      .isLoad  (ldRs1)
   );

   sb_src_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) matchRs2 (
      .entries (entries),
      .srcIdx  (MAX_REG_ADDR_W'(id_rs2)),
      .srcUsed (id_rs2_used),
      .hit     (hitRs2),
      .stage   (stageRs2),
      .isLoad  (ldRs2)
   );

   // A load producer at stage j forwards from stage j+1, which only holds load data once it reaches LOAD_READY_STAGE.
   always_comb begin
      selRs1      = hitRs1 ? stageRs1 + SEL_W'(1) : SEL_W'(FWD_RF);
      selRs2      = hitRs2 ? stageRs2 + SEL_W'(1) : SEL_W'(FWD_RF);
      loadUseRs1  = hitRs1 && ldRs1 && ((int'(stageRs1) + 1) < LOAD_READY_STAGE);
      loadUseRs2  = hitRs2 && ldRs2 && ((int'(stageRs2) + 1) < LOAD_READY_STAGE);
      stall_out   = id_valid && !flush_id && (loadUseRs1 || loadUseRs2);
      pc_write    = !stall_out;
      if_id_write = !stall_out;
      ex_bubble   = stall_out || flush_id || !id_valid;
      issueValid  = id_valid && !flush_id && !stall_out && id_reg_write && (id_rd != '0);
      newEntry    = '{v: issueValid, rd: MAX_REG_ADDR_W'(id_rd), ld: id_is_load};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         entries        <= '0;
         fwd_sel_rs1_ex <= '0;
         fwd_sel_rs2_ex <= '0;
      end else begin
         entries        <= {entries[NUM_STAGES-2:0], newEntry};
         fwd_sel_rs1_ex <= stall_out ? SEL_W'(FWD_RF) : selRs1;
         fwd_sel_rs2_ex <= stall_out ? SEL_W'(FWD_RF) : selRs2;
      end
   end

`ifdef HAZARD_STATS_EN
   // Saturating counters; a forward event is an issued (non-bubble) instruction using any bypass.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stat_stall_cycles <= '0;
         stat_fwd_events   <= '0;
      end else begin
         if (stall_out && (stat_stall_cycles != '1))
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
         if (!ex_bubble && ((selRs1 != '0) || (selRs2 != '0)) && (stat_fwd_events != '1))
            stat_fwd_events <= stat_fwd_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: two configurations (3 stages/load-ready 2 and
// 4 stages/load-ready 3) share one stimulus stream and are checked against a cycle-history model.
module tb_hazard_scoreboard;

   localparam int NCYC = 4096;

   logic       clk = 1'b0;
   logic       resetn;
   logic       idValid, flushId, rs1Used, rs2Used, regWrite, isLoad;
   logic [4:0] rs1, rs2, rd;

   logic       stallA, pcwA, ifwA, bubA;
   logic       stallB, pcwB, ifwB, bubB;
   logic [1:0] f1A, f2A, f1B, f2B;
   logic [31:0] scA, feA, scB, feB;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NUM_STAGES(3), .REG_ADDR_W(5), .LOAD_READY_STAGE(2)) dutA (
      .clk(clk), .resetn(resetn), .id_valid(idValid), .flush_id(flushId),
      .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(rs1Used), .id_rs2_used(rs2Used),
      .id_rd(rd), .id_reg_write(regWrite), .id_is_load(isLoad),
      .stall_out(stallA), .pc_write(pcwA), .if_id_write(ifwA), .ex_bubble(bubA),
      .fwd_sel_rs1_ex(f1A), .fwd_sel_rs2_ex(f2A)
`ifdef HAZARD_STATS_EN
      , .stat_stall_cycles(scA), .stat_fwd_events(feA)
`endif
   );

   hazard_scoreboard #(.NUM_STAGES(4), .REG_ADDR_W(5), .LOAD_READY_STAGE(3)) dutB (
      .clk(clk), .resetn(resetn), .id_valid(idValid), .flush_id(flushId),
      .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(rs1Used), .id_rs2_used(rs2Used),
      .id_rd(rd), .id_reg_write(regWrite), .id_is_load(isLoad),
      .stall_out(stallB), .pc_write(pcwB), .if_id_write(ifwB), .ex_bubble(bubB),
      .fwd_sel_rs1_ex(f1B), .fwd_sel_rs2_ex(f2B)
`ifdef HAZARD_STATS_EN
      , .stat_stall_cycles(scB), .stat_fwd_events(feB)
`endif
   );

`ifndef HAZARD_STATS_EN
   assign scA = '0;
   assign feA = '0;
   assign scB = '0;
   assign feB = '0;
`endif

   typedef struct {
      bit stall, pcw, ifw, bub;
      int f1, f2, sc, fe;
   } exp_t;

   exp_t qA[$];
   exp_t qB[$];
   exp_t monE;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference history: what ID offered to EX in each cycle, per configuration.
   bit         hv  [2][NCYC];
   logic [4:0] hrd [2][NCYC];
   bit         hld [2][NCYC];
   int         lastReset [2] = '{-1, -1};
   int         curF1 [2] = '{0, 0};
   int         curF2 [2] = '{0, 0};
   int         curSc [2] = '{0, 0};
   int         curFe [2] = '{0, 0};

   function automatic int nsOf(input int k);
      return (k == 0) ? 3 : 4;
   endfunction

   function automatic int lrsOf(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag, input exp_t e, input logic st, input logic pw,
                              input logic iw, input logic bb, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [31:0] sc, input logic [31:0] fe);
      chk({tag, ".stall_out"},      {31'd0, st}, {31'd0, e.stall});
      chk({tag, ".pc_write"},       {31'd0, pw}, {31'd0, e.pcw});
      chk({tag, ".if_id_write"},    {31'd0, iw}, {31'd0, e.ifw});
      chk({tag, ".ex_bubble"},      {31'd0, bb}, {31'd0, e.bub});
      chk({tag, ".fwd_sel_rs1_ex"}, {30'd0, s1}, e.f1);
      chk({tag, ".fwd_sel_rs2_ex"}, {30'd0, s2}, e.f2);
`ifdef HAZARD_STATS_EN
      chk({tag, ".stat_stall_cycles"}, sc, e.sc);
      chk({tag, ".stat_fwd_events"},   fe, e.fe);
`else
      if (sc !== fe) $display("[TB] note: unexpected stats tie-off values");
`endif
   endtask

   // Youngest instruction, among those still before WB, that writes the source register.
   task automatic findMatch(input int k, input logic [4:0] src, input bit used,
                            output int sel, output bit ld);
      sel = 0;
      ld  = 1'b0;
      for (int j = 0; j < nsOf(k) - 1; j++) begin
         int c;
         c = cyc - 1 - j;
         if (sel == 0 && c >= 0 && c > lastReset[k] && hv[k][c] && used && src != 5'd0
             && hrd[k][c] == src) begin
            sel = j + 1;
            ld  = hld[k][c];
         end
      end
   endtask

   task automatic applyStimulus(input bit rstn, input bit valid, input bit flush,
                                input logic [4:0] s1, input bit u1, input logic [4:0] s2,
                                input bit u2, input logic [4:0] dst, input bit rw, input bit ld);
      @(posedge clk);
      #1;
      resetn = rstn; idValid = valid; flushId = flush;
      rs1 = s1; rs1Used = u1; rs2 = s2; rs2Used = u2;
      rd = dst; regWrite = rw; isLoad = ld;
      for (int k = 0; k < 2; k++) begin
         int   m1, m2;
         bit   l1, l2, stall;
         exp_t e;
         findMatch(k, s1, u1, m1, l1);
         findMatch(k, s2, u2, m2, l2);
         stall = valid && !flush && ((m1 != 0 && l1 && m1 < lrsOf(k)) ||
                                     (m2 != 0 && l2 && m2 < lrsOf(k)));
         e.stall = stall;
         e.pcw   = !stall;
         e.ifw   = !stall;
         e.bub   = stall || flush || !valid;
         e.f1    = curF1[k];
         e.f2    = curF2[k];
         e.sc    = curSc[k];
         e.fe    = curFe[k];
         if (k == 0) qA.push_back(e); else qB.push_back(e);
         if (!rstn) begin
            hv[k][cyc]   = 1'b0;
            lastReset[k] = cyc;
            curF1[k] = 0; curF2[k] = 0; curSc[k] = 0; curFe[k] = 0;
         end else begin
            hv[k][cyc]  = valid && !flush && !stall && rw && dst != 5'd0;
            hrd[k][cyc] = dst;
            hld[k][cyc] = ld;
            curF1[k] = stall ? 0 : m1;
            curF2[k] = stall ? 0 : m2;
            if (stall) curSc[k]++;
            if (!e.bub && (m1 != 0 || m2 != 0)) curFe[k]++;
         end
      end
      cyc++;
   endtask

   task automatic issue(input logic [4:0] dst, input bit rw, input bit ld, input logic [4:0] s1,
                        input bit u1, input logic [4:0] s2, input bit u2, input bit flush);
      applyStimulus(1'b1, 1'b1, flush, s1, u1, s2, u2, dst, rw, ld);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (qA.size() > 0) begin
         monE = qA.pop_front();
         checkOutput("cfgA", monE, stallA, pcwA, ifwA, bubA, f1A, f2A, scA, feA);
      end
      if (qB.size() > 0) begin
         monE = qB.pop_front();
         checkOutput("cfgB", monE, stallB, pcwB, ifwB, bubB, f1B, f2B, scB, feB);
      end
   end

   initial begin
      resetn = 1'b0; idValid = 1'b1; flushId = 1'b0;
      rs1 = '0; rs2 = '0; rs1Used = 1'b0; rs2Used = 1'b0;
      rd = 5'd5; regWrite = 1'b1; isLoad = 1'b0;

      // Reset held with a live writer of x5 in ID, then a reader of x5 must see no producer.
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      issue(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      idle(3);

      // ALU RAW on x5.
      issue(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
      issue(5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      idle(3);

      // Load-use on x7; consumer held in ID while stalled.
      issue(5'd7, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
      repeat (3) issue(5'd8, 1'b1, 1'b0, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
      idle(4);

      // Youngest producer of x3 wins on both operands.
      issue(5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
      issue(5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
      issue(5'd12, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0);
      idle(3);

      // Loads to x0 never stall; flush overrides a pending load-use and squashes the entry.
      issue(5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
      issue(5'd13, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
      idle(3);
      issue(5'd9, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
      issue(5'd10, 1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
      issue(5'd11, 1'b1, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
      idle(4);

      // Multi-cycle load latency shows up in the 4-stage configuration.
      issue(5'd4, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
      repeat (3) issue(5'd14, 1'b1, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
      idle(4);

      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 99) < 85,
                       $urandom_range(0, 99) < 10,
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)),
                       $urandom_range(0, 99) < 80,
                       $urandom_range(0, 99) < 30);
      end
      idle(2);

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard.drained", qA.size() + qB.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
